// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes one WIDTH-bit word per valid/ready handshake
// and emits it one bit per serial beat with first/last markers and zero-gap reload.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_ser_out,
  output logic             o_ser_valid,
  input  logic             i_ser_ready,
  output logic             o_ser_first,
  output logic             o_ser_last,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_word_cnt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_shift;
  logic             w_last;
  logic             w_beat;
  logic             w_rdy;
  logic             w_accept;
  logic [WIDTH-1:0] w_shreg_nxt;

  assign w_shift  = (r_state == SHIFT);
  assign w_last   = w_shift && (r_cnt == CW'(WIDTH - 1));
  assign w_beat   = w_shift && i_ser_ready;
  assign w_rdy    = !w_shift || (w_last && i_ser_ready);
  assign w_accept = i_in_valid && w_rdy;

  // Shift toward the output end; the vacated bit fills with zero.
  assign w_shreg_nxt = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shreg[WIDTH-1:1]};

  // Ready is forced low while reset is held so nothing is taken mid-reset.
  assign o_in_ready  = i_rst_n && w_rdy;
  assign o_ser_valid = w_shift;
  assign o_busy      = w_shift;
  assign o_ser_out   = w_shift && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
  assign o_ser_first = w_shift && (r_cnt == '0);
  assign o_ser_last  = w_last;
  assign o_word_cnt  = r_word_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_beat && w_last)
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      if (w_accept) begin
        r_shreg <= i_in_data;
        r_cnt   <= '0;
        r_state <= SHIFT;
      end else if (w_beat) begin
        r_shreg <= w_shreg_nxt;
        if (w_last) begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Downstream consumer of the 4-bit parallel-in/parallel-out register stage.
- Accepts one parallel word per valid/ready handshake and shifts it out one bit per accepted serial beat, with first/last frame markers.
- Supports back-to-back words with no idle gap and honours downstream backpressure.
- Keeps a wrapping count of completed words for debug.

Parameters:
- WIDTH, 4, parallel word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- CNT_W, 8, width of the completed-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  parallel word from the upstream register stage.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data at this edge.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream consumes ser_out at this edge.
- ser_first  output  1  ser_out is bit 0 of the frame (first transmitted).
- ser_last  output  1  ser_out is the final bit of the frame.
- busy  output  1  a word is being shifted.
- word_cnt  output  CNT_W  number of completed words, wraps.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, shift register 0, bit counter 0, word_cnt 0. While rst_n is low: ser_valid=0, ser_out=0, ser_first=0, ser_last=0, busy=0, in_ready=0.
- States:
  - IDLE: ser_valid=0.
  - SHIFT: ser_valid=1, busy=1.
- Bit counter: cnt, width clog2(WIDTH), counts transmitted bits 0..WIDTH-1.
- Serial output:
  - ser_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - ser_out is 0 whenever ser_valid=0.
- ser_first = SHIFT and cnt==0.
- ser_last = SHIFT and cnt==WIDTH-1.
- in_ready is combinational: (state==IDLE) OR (SHIFT and ser_last and ser_ready). This gives zero-gap back-to-back operation.
- Accept (in_valid and in_ready at edge): shreg <= in_data, cnt <= 0, state <= SHIFT.
- Latency: first bit is visible in the cycle after the accepting edge.
- Beat (ser_valid and ser_ready at edge):
  - Shift by one toward the output end (left if MSB_FIRST, right otherwise), zero fill.
  - cnt increments.
- Last beat (ser_last and ser_ready):
  - word_cnt increments (wraps from 2^CNT_W-1 to 0).
  - If in_valid: load the new word, stay in SHIFT.
  - Otherwise: go to IDLE, cnt <= 0.
- Backpressure: ser_ready=0 freezes shreg, cnt and ser_out. ser_valid stays 1, since valid must not drop without a handshake.
- in_valid while in SHIFT and not on the last beat: not accepted; upstream must hold in_data.
- Throughput: WIDTH cycles per word with ser_ready held high.
- Reset mid-word: word is discarded, outputs drop immediately (asynchronously), and the partial word is not counted. After release, the block starts clean in IDLE.
- Simultaneous last beat, in_valid and word_cnt wrap: all three actions occur in the same edge.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_data=4'b1111 -> ser_valid=0, in_ready=0, word_cnt=0. Release -> in_ready=1 and nothing transmitted until the next accept.
- Single word 4'b1000, MSB_FIRST=1, ser_ready=1 -> ser_out 1,0,0,0 on cycles 1-4 after accept. ser_first on cycle 1, ser_last on cycle 4, then IDLE, word_cnt=1.
- Back-to-back 4'b1000 then 4'b0101 with in_valid held -> contiguous ser_out 1,0,0,0,0,1,0,1 with no gap. in_ready high only in IDLE and the two last-bit cycles. word_cnt=2.
- Backpressure: drop ser_ready for 3 cycles while on bit 2 of 4'b0101 -> ser_out holds 0, cnt frozen, ser_valid stays 1. Remaining bits 0,1 follow after release.
- Async reset asserted mid-clock after bit 1 of 4'b1010 -> ser_valid falls without waiting for an edge, word_cnt unchanged. Next word 4'b0011 transmits 0,0,1,1 from cnt 0.
- MSB_FIRST=0, word 4'b0101 -> ser_out 1,0,1,0. Separately, send 256 words with CNT_W=8 -> word_cnt wraps to 0 on the 256th last beat.
